npu_mac_engine: RTL and testbench
=================================

# npu_mac_engine

Parametrised multiply-accumulate engine for the NPU, replacing the fixed 3-lane conv/FCN datapath. Host software loads activation and weight buffers over the 32-bit memory-mapped port, writes one command word, and polls status. The engine then runs a multi-tap accumulation autonomously. Lanes are read back either individually (FCN style) or reduced to one sum (conv style), with optional ReLU, arithmetic right-shift and 8-bit saturation.

## Interface
- NUM_PE, 4, number of MAC lanes; NUM_PE*DATA_W ≤ 32
- DATA_W, 8, activation/weight width
- ACC_W, 24, accumulator and result width (≤ 32)
- DEPTH, 16, buffer entries (taps); power of two, ≤ 256
- clk  in  1  single clock, all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- ena  in  1  port enable
- wea  in  1  1 = write, 0 = read (when ena)
- addra  in  16  [14:12] region select, [7:0] index
- dina  in  32  write data
- douta  out  32  registered read data

## Operation
- Address regions (addra[14:12]):
  - 001: write act_buf[addra[clog2(DEPTH)-1:0]].
  - 010: write w_buf[idx].
  - Buffer entry = dina[NUM_PE*DATA_W-1:0]; lane l uses bits [l*DATA_W +: DATA_W].
  - 100 write = command:
    - dina[0] start; dina[1] act_signed (0 = unsigned activations); dina[2] relu; dina[3] reduce; dina[7:4] shift; dina[15:8] len (taps); dina[31] clr_status.
  - 101 read = status {29'0, err, done, busy}.
  - 110 read = result: addra[3]=0 raw, sign-extended to 32; addra[3]=1 q8, sign-extended saturated DATA_W value; addra[1:0] = lane.
  - Reduce mode: the sum is at lane 0; other lanes read 0.
  - Any other region: writes ignored, reads return 0.
- FSM: IDLE → RUN → REDUCE → POST → IDLE.
  - IDLE: on a start with 1 ≤ len ≤ DEPTH, latch mode bits, clear accumulators and tap counter, go to RUN.
  - RUN: each cycle, acc[l] += act_buf[t][l] * w_buf[t][l]; t increments; after tap len-1, go to REDUCE.
  - REDUCE: in reduce mode, sum = Σ acc[l]; otherwise pass-through.
  - POST: v = (value >>> shift); if relu and v < 0 then v = 0; write result registers; set done.
- Arithmetic:
  - Weights are always signed.
  - Activations are zero- or sign-extended to DATA_W+1 per act_signed.
  - Product is 2*DATA_W+1 bits signed, sign-extended to ACC_W.
  - Accumulation and reduction wrap modulo 2^ACC_W (no saturation).
  - q8 clamps v to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Result registers change only in POST and hold their values until the next POST.
- Start with len = 0 or len > DEPTH: not executed, err = 1.
- While busy:
  - Buffer writes and start commands are ignored and set err (sticky).
  - A command word with only clr_status is still accepted.
- clr_status clears done and err. If start and clr_status are in the same word, clear first, then start.
- A new accepted start clears done.

## Timing
- Reset (async assert, sync-safe deassert):
  - state = IDLE; busy, done, err = 0; douta = 0.
  - Accumulators, result registers and both buffers = 0.
- Reset mid-RUN aborts immediately. No result update; done stays 0.
- Writes take effect at the edge where ena & wea.
- Reads: douta updates at the edge after ena & ~wea is sampled, and holds otherwise.
- A start accepted at edge T gives:
  - busy = 1 after T.
  - RUN occupies edges T+1..T+len.
  - REDUCE at T+len+1.
  - POST at T+len+2: result valid, done = 1, busy = 0 after that edge.
- Start-to-done latency is len+2 cycles. Back-to-back starts are possible: the next start may be accepted at edge T+len+3.
- A buffer write at the same edge as a start is accepted (busy still 0) and is visible to tap 0.

## Test plan
- act_buf[0] = {4,3,2,1} (lane0 = 1), w_buf[0] = {1,1,1,1}, cmd len=1 reduce=1 → busy for 3 cycles, done = 1, raw lane0 = 10, q8 = 10, lanes 1–3 read 0.
- act 0xFF, w 0x02 on lane0, lane mode, len=1:
  - act_signed=1 → raw 0xFFFFFFFE, q8 0xFFFFFFFE.
  - Add relu → 0.
  - act_signed=0 → raw 510, q8 127.
- All 16 taps act = 127, w = 127, reduce, len=16 → raw 1032256 (no wrap at ACC_W=24), q8 127. With shift=4 → raw 64516.
- Error paths:
  - len=0 start → err = 1, busy never asserts.
  - Start during RUN → ignored, err = 1, the original result is unaffected.
  - clr_status → err = 0, done = 0.
- Assert rst_ni low during RUN of a len=16 job → status reads 0, results read 0. A fresh len=1 job then completes normally.
- Read result during a busy second job → returns the first job's value until the POST edge, the new value after.

Source files
------------

// File: rtl/npu_mac_engine.sv
// Multi-lane multiply-accumulate engine with memory-mapped buffers, command and status.
// Lanes accumulate per tap, optionally reduce to one sum, then shift/ReLU into result registers.
module npu_mac_engine #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        ena,
    input  logic        wea,
    input  logic [15:0] addra,
    input  logic [31:0] dina,
    output logic [31:0] douta
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ROW_W = NUM_PE * DATA_W;
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);
    localparam int Q_MAX_I = (2 ** (DATA_W - 1)) - 1;
    localparam int Q_MIN_I = -(2 ** (DATA_W - 1));
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(Q_MAX_I);
    localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(Q_MIN_I);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_REDUCE, S_POST} state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0]        act_buf [DEPTH];
    logic [ROW_W-1:0]        w_buf   [DEPTH];
    logic signed [ACC_W-1:0] acc     [NUM_PE];
    logic signed [ACC_W-1:0] res     [NUM_PE];
    logic signed [ACC_W-1:0] prod    [NUM_PE];
    logic signed [ACC_W-1:0] sum;

    logic [8:0] t_q, len_q;
    logic [3:0] shift_q;
    logic       act_signed_q, relu_q, reduce_q;
    logic       done_q, err_q;

    logic [2:0]       region;
    logic [IDX_W-1:0] idx;
    logic [8:0]       cmd_len;
    logic             wr, busy, cmd_wr, start_req, clr_req, len_ok, accept, buf_wr, last_tap;
    logic [ROW_W-1:0] act_row, w_row;
    logic [31:0]      rdata;
    logic             unused_bits;

    function automatic logic signed [ACC_W-1:0] mul_lane(input logic [DATA_W-1:0] a,
                                                         input logic [DATA_W-1:0] w,
                                                         input logic sgn);
        logic signed [DATA_W:0]   ax;
        logic signed [DATA_W-1:0] wx;
        logic signed [2*DATA_W:0] ae, we, p;
        ax = {sgn & a[DATA_W-1], a};
        wx = w;
        ae = (2*DATA_W+1)'(ax);
        we = (2*DATA_W+1)'(wx);
        p  = ae * we;
        return ACC_W'(p);
    endfunction

    function automatic logic signed [ACC_W-1:0] post_val(input logic signed [ACC_W-1:0] value,
                                                         input logic [3:0] sh,
                                                         input logic relu);
        logic signed [ACC_W-1:0] v;
        v = value >>> sh;
        if (relu && (v < 0)) v = '0;
        return v;
    endfunction

    function automatic logic [31:0] sat_q(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > Q_MAX)      r = Q_MAX;
        else if (v < Q_MIN) r = Q_MIN;
        else                r = v;
        return 32'(r);
    endfunction

    assign region    = addra[14:12];
    assign idx       = addra[IDX_W-1:0];
    assign cmd_len   = {1'b0, dina[15:8]};
    assign wr        = ena & wea;
    assign busy      = (state_q != S_IDLE);
    assign cmd_wr    = wr && (region == 3'b100);
    assign start_req = cmd_wr & dina[0];
    assign clr_req   = cmd_wr & dina[31];
    assign len_ok    = (cmd_len != '0) && (cmd_len <= DEPTH_L);
    assign accept    = start_req & ~busy & len_ok;
    assign buf_wr    = wr && ((region == 3'b001) || (region == 3'b010));
    assign last_tap  = (t_q == (len_q - 9'd1));
    assign act_row   = act_buf[t_q[IDX_W-1:0]];
    assign w_row     = w_buf[t_q[IDX_W-1:0]];
    assign unused_bits = ^{addra[15], addra[11:IDX_W], dina[30:16]};

    always_comb begin
        for (int l = 0; l < NUM_PE; l++)
            prod[l] = mul_lane(act_row[l*DATA_W +: DATA_W], w_row[l*DATA_W +: DATA_W], act_signed_q);
    end

    always_comb begin
        sum = '0;
        for (int l = 0; l < NUM_PE; l++)
            sum = sum + acc[l];
    end

    // Buffers are host-writable only while the engine is idle.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                act_buf[i] <= '0;
                w_buf[i]   <= '0;
            end
        end else if (buf_wr && !busy) begin
            if (region == 3'b001) act_buf[idx] <= dina[ROW_W-1:0];
            else                  w_buf[idx]   <= dina[ROW_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_RUN;
            S_RUN:    if (last_tap) state_d = S_REDUCE;
            S_REDUCE: state_d = S_POST;
            S_POST:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            t_q          <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            act_signed_q <= 1'b0;
            relu_q       <= 1'b0;
            reduce_q     <= 1'b0;
            for (int l = 0; l < NUM_PE; l++) begin
                acc[l] <= '0;
                res[l] <= '0;
            end
        end else begin
            if (accept) begin
                t_q          <= '0;
                len_q        <= cmd_len;
                shift_q      <= dina[7:4];
                act_signed_q <= dina[1];
                relu_q       <= dina[2];
                reduce_q     <= dina[3];
                for (int l = 0; l < NUM_PE; l++) acc[l] <= '0;
            end
            case (state_q)
                S_RUN: begin
                    for (int l = 0; l < NUM_PE; l++) acc[l] <= acc[l] + prod[l];
                    t_q <= t_q + 9'd1;
                end
                S_REDUCE: begin
                    // The reduced sum lives in lane 0 so POST treats both modes alike.
                    if (reduce_q) begin
                        for (int l = 0; l < NUM_PE; l++) acc[l] <= (l == 0) ? sum : '0;
                    end
                end
                S_POST: begin
                    for (int l = 0; l < NUM_PE; l++) res[l] <= post_val(acc[l], shift_q, relu_q);
                end
                default: ;
            endcase
        end
    end

    // A clear in the same word as a start is applied before the start is judged.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (clr_req) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (accept) done_q <= 1'b0;
            if (start_req && (busy || !len_ok)) err_q <= 1'b1;
            if (buf_wr && busy) err_q <= 1'b1;
            if (state_q == S_POST) done_q <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (region)
            3'b101: rdata = {29'd0, err_q, done_q, busy};
            3'b110: begin
                for (int l = 0; l < NUM_PE; l++)
                    if (addra[1:0] == 2'(l)) rdata = addra[3] ? sat_q(res[l]) : 32'(res[l]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)        douta <= '0;
        else if (ena & ~wea) douta <= rdata;
    end

endmodule

// File: tb/tb_npu_mac_engine.sv
// Directed bench for npu_mac_engine: vector table of single-tap jobs plus
// hand-written sequences for timing, long jobs, error paths and reset.
module tb_npu_mac_engine;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ena = 1'b0;
    logic        wea = 1'b0;
    logic [15:0] addra = '0;
    logic [31:0] dina = '0;
    logic [31:0] douta;

    int checks = 0;
    int failures = 0;

    localparam logic [15:0] A_ACT  = 16'h1000;
    localparam logic [15:0] A_W    = 16'h2000;
    localparam logic [15:0] A_CMD  = 16'h4000;
    localparam logic [15:0] A_STAT = 16'h5000;
    localparam logic [15:0] A_RAW  = 16'h6000;
    localparam logic [15:0] A_Q8   = 16'h6008;

    typedef struct {
        logic [31:0] act;
        logic [31:0] w;
        logic [31:0] cmdw;
        logic [31:0] raw0;
        logic [31:0] q80;
        logic [31:0] raw1;
    } vec_t;

    vec_t vt[8];

    npu_mac_engine #(.NUM_PE(4), .DATA_W(8), .ACC_W(24), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_ni(rst_ni),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cmd(input logic start, input logic sgn, input logic relu,
                                        input logic red, input logic [3:0] sh,
                                        input logic [7:0] len, input logic clr);
        return {clr, 15'd0, len, sh, red, relu, sgn, start};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        ena = 1'b1; wea = 1'b1; addra = addr; dina = data;
        @(negedge clk);
        ena = 1'b0; wea = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
        @(negedge clk);
        ena = 1'b1; wea = 1'b0; addra = addr;
        @(negedge clk);
        ena = 1'b0;
        data = douta;
    endtask

    task automatic wait_done(input string name);
        logic [31:0] s;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus_read(A_STAT, s);
            if (s[1]) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done: got done=0 after 100 polls required done=1", name);
        end
    endtask

    task automatic run_job(input logic [31:0] cw, input string name);
        bus_write(A_CMD, cw);
        wait_done(name);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] st[4];
        logic [31:0] rr[20];

        vt[0] = '{32'h04030201, 32'h01010101, cmd(1,0,0,1,4'd0,8'd1,1), 32'h0000000A, 32'h0000000A, 32'h0};
        vt[1] = '{32'h000000FF, 32'h00000002, cmd(1,1,0,0,4'd0,8'd1,1), 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0};
        vt[2] = '{32'h000000FF, 32'h00000002, cmd(1,1,1,0,4'd0,8'd1,1), 32'h00000000, 32'h00000000, 32'h0};
        vt[3] = '{32'h000000FF, 32'h00000002, cmd(1,0,0,0,4'd0,8'd1,1), 32'h000001FE, 32'h0000007F, 32'h0};
        vt[4] = '{32'h00001005, 32'h0000FD03, cmd(1,1,0,0,4'd0,8'd1,1), 32'h0000000F, 32'h0000000F, 32'hFFFFFFD0};
        vt[5] = '{32'h00000080, 32'h0000007F, cmd(1,1,0,0,4'd3,8'd1,1), 32'hFFFFF810, 32'hFFFFFF80, 32'h0};
        vt[6] = '{32'h80FF7F01, 32'h01FF0202, cmd(1,0,0,1,4'd0,8'd1,1), 32'h00000081, 32'h0000007F, 32'h0};
        vt[7] = '{32'h00000080, 32'h00000080, cmd(1,0,0,0,4'd0,8'd1,1), 32'hFFFFC000, 32'hFFFFFF80, 32'h0};

        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        check("reset_douta", douta, 32'h0);
        bus_read(A_STAT, rd); check("reset_status", rd, 32'h0);
        bus_read(A_RAW, rd);  check("reset_raw0", rd, 32'h0);
        bus_read(A_Q8, rd);   check("reset_q80", rd, 32'h0);

        // Cycle-exact busy window for a one-tap job.
        bus_write(A_ACT, 32'h04030201);
        bus_write(A_W, 32'h01010101);
        @(negedge clk);
        ena = 1'b1; wea = 1'b1; addra = A_CMD; dina = cmd(1,0,0,1,4'd0,8'd1,0);
        @(negedge clk);
        wea = 1'b0; addra = A_STAT;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            st[i] = douta;
        end
        ena = 1'b0;
        check("busy_cyc1", st[0], 32'h1);
        check("busy_cyc2", st[1], 32'h1);
        check("busy_cyc3", st[2], 32'h1);
        check("done_cyc4", st[3], 32'h2);
        bus_read(A_RAW, rd);         check("sum_raw0", rd, 32'd10);
        bus_read(A_Q8, rd);          check("sum_q80", rd, 32'd10);
        bus_read(A_RAW | 16'h1, rd); check("sum_raw1", rd, 32'h0);
        bus_read(A_RAW | 16'h2, rd); check("sum_raw2", rd, 32'h0);
        bus_read(A_RAW | 16'h3, rd); check("sum_raw3", rd, 32'h0);

        for (int v = 0; v < 8; v++) begin
            bus_write(A_ACT, vt[v].act);
            bus_write(A_W, vt[v].w);
            run_job(vt[v].cmdw, $sformatf("vec%0d", v));
            bus_read(A_RAW, rd);         check($sformatf("vec%0d_raw0", v), rd, vt[v].raw0);
            bus_read(A_Q8, rd);          check($sformatf("vec%0d_q80", v), rd, vt[v].q80);
            bus_read(A_RAW | 16'h1, rd); check($sformatf("vec%0d_raw1", v), rd, vt[v].raw1);
        end

        for (int i = 0; i < 16; i++) begin
            bus_write(A_ACT | 16'(i), 32'h7F7F7F7F);
            bus_write(A_W | 16'(i), 32'h7F7F7F7F);
        end
        run_job(cmd(1,0,0,1,4'd0,8'd16,1), "taps16");
        bus_read(A_RAW, rd); check("taps16_raw0", rd, 32'd1032256);
        bus_read(A_Q8, rd);  check("taps16_q80", rd, 32'd127);
        run_job(cmd(1,1,0,1,4'd4,8'd16,1), "taps16_sh4");
        bus_read(A_RAW, rd); check("taps16_sh4_raw0", rd, 32'd64516);

        bus_write(A_CMD, cmd(0,0,0,0,4'd0,8'd0,1));
        bus_read(A_STAT, rd); check("clr_status", rd, 32'h0);
        bus_write(A_CMD, cmd(1,0,0,1,4'd0,8'd0,0));
        for (int i = 0; i < 3; i++) begin
            bus_read(A_STAT, rd); check($sformatf("len0_status%0d", i), rd, 32'h4);
        end
        bus_write(A_CMD, cmd(0,0,0,0,4'd0,8'd0,1));
        bus_write(A_CMD, cmd(1,0,0,1,4'd0,8'd17,0));
        bus_read(A_STAT, rd); check("len17_status", rd, 32'h4);

        // Start and buffer write while busy must both be ignored and flag err.
        bus_write(A_CMD, cmd(1,0,0,1,4'd0,8'd16,1));
        bus_write(A_CMD, cmd(1,0,0,0,4'd4,8'd1,0));
        bus_write(A_ACT | 16'hF, 32'h0);
        wait_done("busy_start");
        bus_read(A_STAT, rd); check("busy_start_status", rd, 32'h6);
        bus_read(A_RAW, rd);  check("busy_start_raw0", rd, 32'd1032256);
        bus_write(A_CMD, cmd(0,0,0,0,4'd0,8'd0,1));
        bus_read(A_STAT, rd); check("clr_after_err", rd, 32'h0);

        // Result holds the previous job's value until the POST edge of the next one.
        @(negedge clk);
        ena = 1'b1; wea = 1'b1; addra = A_CMD; dina = cmd(1,0,0,1,4'd4,8'd16,0);
        @(negedge clk);
        wea = 1'b0; addra = A_RAW;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rr[i] = douta;
        end
        ena = 1'b0;
        check("hold_first", rr[0], 32'd1032256);
        check("hold_pre_post", rr[17], 32'd1032256);
        check("new_after_post", rr[18], 32'd64516);
        check("new_stable", rr[19], 32'd64516);
        bus_read(A_STAT, rd); check("second_job_status", rd, 32'h2);

        bus_write(A_CMD, cmd(1,0,0,1,4'd0,8'd16,1));
        repeat (5) @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        check("midrun_douta", douta, 32'h0);
        bus_read(A_STAT, rd); check("midrun_status", rd, 32'h0);
        bus_read(A_RAW, rd);  check("midrun_raw0", rd, 32'h0);
        repeat (20) @(negedge clk);
        bus_read(A_STAT, rd); check("midrun_status_later", rd, 32'h0);
        run_job(cmd(1,0,0,1,4'd0,8'd1,1), "post_reset_zero");
        bus_read(A_RAW, rd);  check("post_reset_zero_raw0", rd, 32'h0);
        bus_write(A_ACT, 32'h04030201);
        bus_write(A_W, 32'h01010101);
        run_job(cmd(1,0,0,1,4'd0,8'd1,1), "post_reset_job");
        bus_read(A_RAW, rd);  check("post_reset_raw0", rd, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
